// File: rtl/clock_switch_sequencer_pkg.sv
// Shared types and helpers for the clock switch sequencer.
//   state_e : controller FSM states
//   max     : larger of two unsigned values, used to size the shared countdown timer
package clock_switch_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSettling = 2'd1,
        StDwell    = 2'd2
    } state_e;

    function automatic int unsigned max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_switch_sequencer_if.sv
// Request handshake and status bundle of the clock switch sequencer.
//   request_valid / request_select / request_ready : switch request handshake
//   select          : registered mux select
//   switching       : high while the mux synchronizers settle
//   switch_done     : one-cycle completion pulse
//   current_select  : last fully settled selection
// master: requester side; slave: the sequencer.
interface clock_switch_sequencer_if;

    logic request_valid;
    logic request_select;
    logic request_ready;
    logic select;
    logic switching;
    logic switch_done;
    logic current_select;

    modport master (
        output request_valid,
        output request_select,
        input  request_ready,
        input  select,
        input  switching,
        input  switch_done,
        input  current_select
    );

    modport slave (
        input  request_valid,
        input  request_select,
        output request_ready,
        output select,
        output switching,
        output switch_done,
        output current_select
    );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a zero flag, shared by the settle and dwell phases.
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset (counter clears to 0)
//   load_i       : load load_value_i this cycle (takes priority over counting)
//   load_value_i : value to load
//   zero_o       : counter currently reads 0
// The counter stops at 0 rather than wrapping; it is always reloaded before use.
module countdown_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/clock_switch_sequencer.sv
// Drives the select input of a glitch-free clock mux from an always-on reference clock.
// A request that changes the selection toggles select, then holds the request channel
// closed for a settle window (covering the mux synchronizer latency) followed by a
// minimum dwell window. Completion is reported with a one-cycle switch_done pulse.
//   clock   : reference clock, rising edge
//   reset   : asynchronous active-high reset
//   ctrl_io : request handshake and status (slave side)
module clock_switch_sequencer
    import clock_switch_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES    = 16,
    parameter int unsigned MIN_DWELL_CYCLES = 64,
    parameter bit          INITIAL_SELECT   = 1'b0
) (
    input logic                      clock,
    input logic                      reset,
    clock_switch_sequencer_if.slave  ctrl_io
);

    localparam int unsigned CntW = $clog2(max(SETTLE_CYCLES, MIN_DWELL_CYCLES) + 1);
    localparam int unsigned SettleLoadInt = SETTLE_CYCLES - 1;
    localparam int unsigned DwellLoadInt  = (MIN_DWELL_CYCLES == 0) ? 0 : MIN_DWELL_CYCLES - 1;
    localparam logic [CntW-1:0] SettleLoad = CntW'(SettleLoadInt);
    localparam logic [CntW-1:0] DwellLoad  = CntW'(DwellLoadInt);
    localparam bit SkipDwell = (MIN_DWELL_CYCLES == 0);

    state_e          state_q, state_d;
    logic            select_q, select_d;
    logic            current_q, current_d;
    logic            done_q, done_d;
    logic            switching_q, switching_d;
    logic            timer_load;
    logic [CntW-1:0] timer_value;
    logic            timer_zero;

    countdown_timer #(
        .Width (CntW)
    ) u_timer (
        .clk_i        (clock),
        .rst_i        (reset),
        .load_i       (timer_load),
        .load_value_i (timer_value),
        .zero_o       (timer_zero)
    );

    always_comb begin
        state_d     = state_q;
        select_d    = select_q;
        current_d   = current_q;
        done_d      = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;

        unique case (state_q)
            StIdle: begin
                if (ctrl_io.request_valid) begin
                    if (ctrl_io.request_select != select_q) begin
                        select_d    = ctrl_io.request_select;
                        timer_load  = 1'b1;
                        timer_value = SettleLoad;
                        state_d     = StSettling;
                    end else begin
                        // Already on the requested clock: acknowledge without settling.
                        done_d = 1'b1;
                    end
                end
            end
            StSettling: begin
                if (timer_zero) begin
                    current_d = select_q;
                    done_d    = 1'b1;
                    if (SkipDwell) begin
                        state_d = StIdle;
                    end else begin
                        timer_load  = 1'b1;
                        timer_value = DwellLoad;
                        state_d     = StDwell;
                    end
                end
            end
            StDwell: begin
                if (timer_zero) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered so switching covers exactly the cycles spent in SETTLING.
        switching_d = (state_d == StSettling);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            select_q    <= INITIAL_SELECT;
            current_q   <= INITIAL_SELECT;
            done_q      <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            select_q    <= select_d;
            current_q   <= current_d;
            done_q      <= done_d;
            switching_q <= switching_d;
        end
    end

    assign ctrl_io.request_ready  = (state_q == StIdle);
    assign ctrl_io.select         = select_q;
    assign ctrl_io.switching      = switching_q;
    assign ctrl_io.switch_done    = done_q;
    assign ctrl_io.current_select = current_q;

endmodule

// File: tb/tb_clock_switch_sequencer.sv
// Self-checking bench for clock_switch_sequencer. Two instances: A with the default
// 16/64 timing, B with SETTLE=1, no dwell and INITIAL_SELECT=1. Expected completions are
// queued when a request is issued; per-instance monitors pop them on switch_done.
module tb_clock_switch_sequencer;

    typedef struct {
        logic sel;
        int   cycle;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    clock_switch_sequencer_if bus_a ();
    clock_switch_sequencer_if bus_b ();

    clock_switch_sequencer #(
        .SETTLE_CYCLES    (16),
        .MIN_DWELL_CYCLES (64),
        .INITIAL_SELECT   (1'b0)
    ) dut_a (
        .clock   (clock),
        .reset   (reset),
        .ctrl_io (bus_a)
    );

    clock_switch_sequencer #(
        .SETTLE_CYCLES    (1),
        .MIN_DWELL_CYCLES (0),
        .INITIAL_SELECT   (1'b1)
    ) dut_b (
        .clock   (clock),
        .reset   (reset),
        .ctrl_io (bus_b)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors: every switch_done must match the oldest queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus_a.switch_done) begin
            if (qa.size() == 0) begin
                check("a_unexpected_done", int'(bus_a.switch_done), 0);
            end else begin
                e = qa.pop_front();
                check("a_done_cycle", cyc, e.cycle);
                check("a_done_current_select", int'(bus_a.current_select), int'(e.sel));
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && bus_b.switch_done) begin
            if (qb.size() == 0) begin
                check("b_unexpected_done", int'(bus_b.switch_done), 0);
            end else begin
                e = qb.pop_front();
                check("b_done_cycle", cyc, e.cycle);
                check("b_done_current_select", int'(bus_b.current_select), int'(e.sel));
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        bus_a.request_valid  = 1'b0;
        bus_a.request_select = 1'b0;
        bus_b.request_valid  = 1'b0;
        bus_b.request_select = 1'b0;
        repeat (3) @(negedge clock);
        check("a_reset_select", int'(bus_a.select), 0);
        check("b_reset_select", int'(bus_b.select), 1);
        reset = 1'b0;
        @(negedge clock);

        // Reset values after release.
        check("a_rel_select", int'(bus_a.select), 0);
        check("a_rel_current", int'(bus_a.current_select), 0);
        check("a_rel_ready", int'(bus_a.request_ready), 1);
        check("a_rel_switching", int'(bus_a.switching), 0);
        check("a_rel_done", int'(bus_a.switch_done), 0);
        check("b_rel_select", int'(bus_b.select), 1);
        check("b_rel_current", int'(bus_b.current_select), 1);
        check("b_rel_ready", int'(bus_b.request_ready), 1);

        // Five back-to-back no-ops: one pulse each, ready never drops.
        for (int i = 0; i < 5; i++) begin
            check("a_noop_ready", int'(bus_a.request_ready), 1);
            bus_a.request_valid  = 1'b1;
            bus_a.request_select = 1'b0;
            qa.push_back('{sel: 1'b0, cycle: cyc + 1});
            @(negedge clock);
        end
        bus_a.request_valid = 1'b0;
        check("a_noop_ready_after", int'(bus_a.request_ready), 1);
        check("a_noop_select", int'(bus_a.select), 0);
        check("a_noop_switching", int'(bus_a.switching), 0);
        repeat (2) @(negedge clock);

        // Real switch to 1; valid stays high with a toggling select while busy.
        check("a_sw1_ready", int'(bus_a.request_ready), 1);
        bus_a.request_valid  = 1'b1;
        bus_a.request_select = 1'b1;
        n = cyc;
        qa.push_back('{sel: 1'b1, cycle: n + 17});
        for (int k = 1; k <= 80; k++) begin
            @(negedge clock);
            check("a_sw1_select", int'(bus_a.select), 1);
            check("a_sw1_switching", int'(bus_a.switching), (k <= 16) ? 1 : 0);
            check("a_sw1_ready_low", int'(bus_a.request_ready), 0);
            bus_a.request_select = 1'(k);
        end
        @(negedge clock);
        check("a_sw1_ready_back", int'(bus_a.request_ready), 1);
        check("a_sw1_ready_cycle", cyc, n + 81);

        // Value present at acceptance is used: switch back to 0.
        bus_a.request_select = 1'b0;
        n = cyc;
        qa.push_back('{sel: 1'b0, cycle: n + 17});
        @(negedge clock);
        bus_a.request_valid = 1'b0;
        check("a_sw0_select", int'(bus_a.select), 0);
        check("a_sw0_switching", int'(bus_a.switching), 1);
        check("a_sw0_ready", int'(bus_a.request_ready), 0);
        repeat (79) @(negedge clock);
        check("a_sw0_ready_still_low", int'(bus_a.request_ready), 0);
        @(negedge clock);
        check("a_sw0_ready_back", int'(bus_a.request_ready), 1);

        // Instance B: settle 1, no dwell.
        check("b_sw_ready", int'(bus_b.request_ready), 1);
        bus_b.request_valid  = 1'b1;
        bus_b.request_select = 1'b0;
        n = cyc;
        qb.push_back('{sel: 1'b0, cycle: n + 2});
        @(negedge clock);
        bus_b.request_valid = 1'b0;
        check("b_sw_select", int'(bus_b.select), 0);
        check("b_sw_switching", int'(bus_b.switching), 1);
        check("b_sw_ready_low", int'(bus_b.request_ready), 0);
        @(negedge clock);
        check("b_sw_ready_with_done", int'(bus_b.request_ready), 1);
        check("b_sw_switching_off", int'(bus_b.switching), 0);
        @(negedge clock);

        // Reset in the middle of SETTLING on A.
        bus_a.request_valid  = 1'b1;
        bus_a.request_select = 1'b1;
        @(negedge clock);
        bus_a.request_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("a_mid_switching", int'(bus_a.switching), 1);
        check("a_mid_select", int'(bus_a.select), 1);
        #2 reset = 1'b1;
        #1;
        check("a_rst_select", int'(bus_a.select), 0);
        check("a_rst_switching", int'(bus_a.switching), 0);
        check("a_rst_ready", int'(bus_a.request_ready), 1);
        check("a_rst_current", int'(bus_a.current_select), 0);
        check("a_rst_done", int'(bus_a.switch_done), 0);
        check("b_rst_select", int'(bus_b.select), 1);
        check("b_rst_current", int'(bus_b.current_select), 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("a_post_rst_select", int'(bus_a.select), 0);
        check("a_post_rst_ready", int'(bus_a.request_ready), 1);

        // Every queued completion must have arrived.
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
